ysyx_23060025_write_buffer: RTL

//  Single-entry write buffer directly downstream of the dcache. Captures one write per request:
//  a dirty-line writeback or an uncached store. Drains it as an AXI4 write (AW/W/B) to the memory arbiter.

---
 rtl/ysyx_23060025_write_buffer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ysyx_23060025_write_buffer.sv
// ysyx_23060025_write_buffer
//   Single-entry write buffer sitting directly behind the dcache. It takes one
//   write per request, either a dirty-line writeback or an uncached
//   byte/half/word store. It then drains that write as one AXI4 write burst
//   (AW/W/B) toward the memory arbiter. in_pwrdy is high only while the entry
//   is empty. The dcache starts a miss or replace only when in_pwrdy is high.
//
//   Ports
//     clock, reset          clock; synchronous active-high reset
//     in_pwr_req ... rdy    request side from the dcache (addr, line data,
//                           strobes, type)
//     out_aw* / out_w* /    AXI4 write address, data and response channels
//     out_b*
//     out_werr              sticky error flag: any non-OKAY bresp since reset
//     chk_addr / chk_hit    read-after-write hazard probe for dcache refills
//
//   Configuration
//     YSYX_23060025_WBUF_RAW_CHECK_EN  when defined, chk_hit compares the line of
//                                      chk_addr against the pending entry.
//                                      Otherwise chk_hit is tied to 0.

module ysyx_23060025_write_buffer #(
    parameter int ADDR_WIDTH            = 32,
    parameter int DATA_WIDTH            = 32,
    parameter int CACHE_LINE_OFF_ADDR_W = 4
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     in_pwr_req,
    input  logic [ADDR_WIDTH-1:0]                    in_pwaddr,
    input  logic [8*(1<<CACHE_LINE_OFF_ADDR_W)-1:0]  in_pwdata,
    input  logic [3:0]                               in_pwstrb,
    input  logic [2:0]                               in_pwtype,
    output logic                                     in_pwrdy,
    output logic                                     out_awvalid,
    input  logic                                     out_awready,
    output logic [ADDR_WIDTH-1:0]                    out_awaddr,
    output logic [7:0]                               out_awlen,
    output logic [2:0]                               out_awsize,
    output logic [1:0]                               out_awburst,
    output logic                                     out_wvalid,
    input  logic                                     out_wready,
    output logic [DATA_WIDTH-1:0]                    out_wdata,
    output logic [3:0]                               out_wstrb,
    output logic                                     out_wlast,
    input  logic                                     out_bvalid,
    output logic                                     out_bready,
    input  logic [1:0]                               out_bresp,
    output logic                                     out_werr,
    input  logic [ADDR_WIDTH-1:0]                    chk_addr,
    output logic                                     chk_hit
);

    localparam int BEATS = (1 << CACHE_LINE_OFF_ADDR_W) / 4;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {IDLE, SEND, RESP} state_t;

    state_t state, state_nxt;

    // Buffered write entry.
    logic [ADDR_WIDTH-1:0]             e_addr;
    logic [BEATS-1:0][DATA_WIDTH-1:0]  e_data;
    logic [3:0]                        e_strb;
    logic                              e_line;
    logic [2:0]                        e_size;

    logic             aw_done;  // AW handshake already taken this burst
    logic             w_done;   // wlast handshake already taken this burst
    logic [CNT_W-1:0] beat;

    logic aw_hs, w_hs, last_beat, w_last_hs, accept;

    assign accept    = (state == IDLE) && in_pwr_req;
    assign aw_hs     = out_awvalid && out_awready;
    assign w_hs      = out_wvalid && out_wready;
    assign last_beat = !e_line || (beat == CNT_W'(BEATS - 1));
    assign w_last_hs = w_hs && last_beat;

    // Entry capture. Requests outside IDLE never reach the entry.
    always_ff @(posedge clock) begin
        if (accept) begin
            e_addr <= in_pwaddr;
            e_data <= in_pwdata;
            e_strb <= in_pwstrb;
            e_line <= (in_pwtype == 3'b100);
            // Byte and half keep their native size; all other encodings act as word.
            case (in_pwtype)
                3'b000:  e_size <= 3'b000;
                3'b001:  e_size <= 3'b001;
                default: e_size <= 3'b010;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            beat     <= '0;
            out_werr <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                beat    <= '0;
            end
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs) begin
                if (last_beat) w_done <= 1'b1;
                else           beat   <= beat + 1'b1;
            end
            if (state == RESP && out_bvalid && out_bresp != 2'b00) out_werr <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_pwr_req) state_nxt = SEND;
            // AW and the final W beat may complete in either order or together.
            SEND: if ((aw_done || aw_hs) && (w_done || w_last_hs)) state_nxt = RESP;
            RESP: if (out_bvalid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign in_pwrdy    = (state == IDLE);
    assign out_awvalid = (state == SEND) && !aw_done;
    assign out_wvalid  = (state == SEND) && !w_done;
    assign out_bready  = (state == RESP);

    // Payloads are derived only from the entry and the beat counter, so they
    // stay stable while a valid waits for its ready.
    assign out_awaddr  = e_addr;
    assign out_awlen   = e_line ? 8'(BEATS - 1) : 8'd0;
    assign out_awsize  = e_line ? 3'b010 : e_size;
    assign out_awburst = 2'b01;
    assign out_wdata   = e_line ? e_data[beat] : e_data[0];
    assign out_wstrb   = e_line ? 4'hF : e_strb;
    assign out_wlast   = last_beat;

`ifdef YSYX_23060025_WBUF_RAW_CHECK_EN
    assign chk_hit = (state != IDLE) &&
        (chk_addr[ADDR_WIDTH-1:CACHE_LINE_OFF_ADDR_W] == e_addr[ADDR_WIDTH-1:CACHE_LINE_OFF_ADDR_W]);
`else
    logic unused_chk;
    assign unused_chk = ^chk_addr;
    assign chk_hit    = 1'b0;
`endif

endmodule
